// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - RV32I decode encodings, immediate formats and ID/EX register layout
package riscv_pkg;

    localparam int XLEN  = 32;
    localparam int REG_W = 5;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_J, IMM_U} imm_src_t;

    typedef struct packed {
        logic [XLEN-1:0]  rd1;
        logic [XLEN-1:0]  rd2;
        logic [XLEN-1:0]  imm;
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  pc4;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        logic             reg_write;
        logic             mem_write;
        logic             mem_read;
        logic             alu_src;
        logic             branch;
        logic             jump;
        logic [1:0]       result_src;
        logic [2:0]       alu_control;
    } id_ex_t;

    function automatic logic [XLEN-1:0] gen_imm(input logic [31:0] ins, input imm_src_t src);
        case (src)
            IMM_S:   gen_imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B:   gen_imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_J:   gen_imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            IMM_U:   gen_imm = {ins[31:12], 12'b0};
            default: gen_imm = {{20{ins[31]}}, ins[31:20]};
        endcase
    endfunction

endpackage

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 32-entry register file, two async reads, one write, x0 hardwired, write bypass
module reg_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd
);

    logic [DATA_W-1:0] regs [0:(1<<ADDR_W)-1];
    logic              wr_en;

    assign wr_en = we && (wa != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < (1 << ADDR_W); i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[wa] <= wd;
        end
    end

    // Writeback lands in the same cycle it is read, so decode sees it without waiting an edge
    assign rd1 = (ra1 == '0) ? '0 : (wr_en && wa == ra1) ? wd : regs[ra1];
    assign rd2 = (ra2 == '0) ? '0 : (wr_en && wa == ra2) ? wd : regs[ra2];

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I ID stage: decode, register read, immediate, hazard detect, ID/EX register
module decode_stage
    import riscv_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] Ins_D,
    input  logic [ADDR_WIDTH-1:0] PC_D,
    input  logic [ADDR_WIDTH-1:0] PC_4D,
    input  logic                  PCSrc_E,
    input  logic                  RegWrite_W,
    input  logic [REG_ADDR_W-1:0] Rd_W,
    input  logic [ADDR_WIDTH-1:0] Result_W,
    output logic                  PC_Write,
    output logic                  IF_ID_Write,
    output logic [ADDR_WIDTH-1:0] RD1_E,
    output logic [ADDR_WIDTH-1:0] RD2_E,
    output logic [ADDR_WIDTH-1:0] Imm_E,
    output logic [ADDR_WIDTH-1:0] PC_E,
    output logic [ADDR_WIDTH-1:0] PC_4E,
    output logic [REG_ADDR_W-1:0] Rs1_E,
    output logic [REG_ADDR_W-1:0] Rs2_E,
    output logic [REG_ADDR_W-1:0] Rd_E,
    output logic                  RegWrite_E,
    output logic                  MemWrite_E,
    output logic                  MemRead_E,
    output logic                  ALUSrc_E,
    output logic                  Branch_E,
    output logic                  Jump_E,
    output logic [1:0]            ResultSrc_E,
    output logic [2:0]            ALUControl_E
);

    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [REG_ADDR_W-1:0] rs1_raw, rs1_sel, rs2, rd;
    logic [2:0]            alu_funct;
    logic                  uses_rs2, stall;
    imm_src_t              imm_src;
    id_ex_t                id_ex_d, id_ex_q;
    logic [ADDR_WIDTH-1:0] rf_rd1, rf_rd2;

    assign opcode  = Ins_D[6:0];
    assign funct3  = Ins_D[14:12];
    assign rs1_raw = Ins_D[19:15];
    assign rs2     = Ins_D[24:20];
    assign rd      = Ins_D[11:7];

    always_comb begin
        case (funct3)
            3'b000:  alu_funct = (opcode == OP_R && Ins_D[30]) ? ALU_SUB : ALU_ADD;
            3'b111:  alu_funct = ALU_AND;
            3'b110:  alu_funct = ALU_OR;
            3'b010:  alu_funct = ALU_SLT;
            default: alu_funct = ALU_ADD;
        endcase
    end

    always_comb begin
        id_ex_d  = '0;
        imm_src  = IMM_I;
        rs1_sel  = rs1_raw;
        uses_rs2 = 1'b0;
        case (opcode)
            OP_R: begin
                id_ex_d.reg_write   = 1'b1;
                id_ex_d.alu_control = alu_funct;
                uses_rs2            = 1'b1;
            end
            OP_I: begin
                id_ex_d.reg_write   = 1'b1;
                id_ex_d.alu_src     = 1'b1;
                id_ex_d.alu_control = alu_funct;
            end
            OP_LOAD: begin
                id_ex_d.reg_write  = 1'b1;
                id_ex_d.mem_read   = 1'b1;
                id_ex_d.alu_src    = 1'b1;
                id_ex_d.result_src = RES_MEM;
            end
            OP_STORE: begin
                id_ex_d.mem_write = 1'b1;
                id_ex_d.alu_src   = 1'b1;
                imm_src           = IMM_S;
                uses_rs2          = 1'b1;
            end
            OP_BRANCH: begin
                id_ex_d.branch      = 1'b1;
                id_ex_d.alu_control = ALU_SUB;
                imm_src             = IMM_B;
                uses_rs2            = 1'b1;
            end
            OP_JAL: begin
                id_ex_d.reg_write  = 1'b1;
                id_ex_d.jump       = 1'b1;
                id_ex_d.result_src = RES_PC4;
                imm_src            = IMM_J;
            end
            OP_LUI: begin
                // lui is executed as x0 + imm on the ALU
                id_ex_d.reg_write = 1'b1;
                id_ex_d.alu_src   = 1'b1;
                imm_src           = IMM_U;
                rs1_sel           = '0;
            end
            default: ;
        endcase
        id_ex_d.rd1 = rf_rd1;
        id_ex_d.rd2 = rf_rd2;
        id_ex_d.imm = gen_imm(Ins_D, imm_src);
        id_ex_d.pc  = PC_D;
        id_ex_d.pc4 = PC_4D;
        id_ex_d.rs1 = rs1_sel;
        id_ex_d.rs2 = rs2;
        id_ex_d.rd  = rd;
    end

    reg_file #(.DATA_W(ADDR_WIDTH), .ADDR_W(REG_ADDR_W)) u_reg_file (
        .clk   (clk),
        .rst_n (rst_n),
        .ra1   (rs1_sel),
        .ra2   (rs2),
        .rd1   (rf_rd1),
        .rd2   (rf_rd2),
        .we    (RegWrite_W),
        .wa    (Rd_W),
        .wd    (Result_W)
    );

    assign stall = id_ex_q.mem_read && (id_ex_q.rd != '0) &&
                   ((id_ex_q.rd == rs1_raw) || (uses_rs2 && id_ex_q.rd == rs2));

    // A redirect in EX discards the stalled instruction anyway, so fetch must advance
    assign PC_Write    = PCSrc_E || !stall;
    assign IF_ID_Write = PCSrc_E || !stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                id_ex_q <= '0;
        else if (PCSrc_E || stall) id_ex_q <= '0;
        else                       id_ex_q <= id_ex_d;
    end

    assign RD1_E        = id_ex_q.rd1;
    assign RD2_E        = id_ex_q.rd2;
    assign Imm_E        = id_ex_q.imm;
    assign PC_E         = id_ex_q.pc;
    assign PC_4E        = id_ex_q.pc4;
    assign Rs1_E        = id_ex_q.rs1;
    assign Rs2_E        = id_ex_q.rs2;
    assign Rd_E         = id_ex_q.rd;
    assign RegWrite_E   = id_ex_q.reg_write;
    assign MemWrite_E   = id_ex_q.mem_write;
    assign MemRead_E    = id_ex_q.mem_read;
    assign ALUSrc_E     = id_ex_q.alu_src;
    assign Branch_E     = id_ex_q.branch;
    assign Jump_E       = id_ex_q.jump;
    assign ResultSrc_E  = id_ex_q.result_src;
    assign ALUControl_E = id_ex_q.alu_control;

endmodule
